// File: rtl/inst_rom_loader_pkg.sv
// Shared types and constants for the instruction ROM loader.
package inst_rom_loader_pkg;

  localparam int unsigned InstBus = 32;
  localparam logic [InstBus-1:0] ZeroWord = '0;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } rom_state_e;

endpackage

// File: rtl/rom_word_packer.sv
// Packs load bytes big-endian into 32-bit words and zero-pads a short final word.
module rom_word_packer
  import inst_rom_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               take,
  input  logic [7:0]         ld_byte,
  input  logic               ld_last,
  output logic [InstBus-1:0] word,
  output logic               we
);

  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [InstBus-1:0] word_buf_q, word_buf_d;

  // Bytes are dropped straight into their final lane, so unfilled lanes stay zero as padding.
  always_comb begin
    word = word_buf_q;
    case (byte_cnt_q)
      2'd0:    word[31:24] = ld_byte;
      2'd1:    word[23:16] = ld_byte;
      2'd2:    word[15:8]  = ld_byte;
      default: word[7:0]   = ld_byte;
    endcase
    we = take && ((byte_cnt_q == 2'd3) || ld_last);

    byte_cnt_d = byte_cnt_q;
    word_buf_d = word_buf_q;
    if (clr || we) begin
      byte_cnt_d = '0;
      word_buf_d = '0;
    end else if (take) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      word_buf_d = word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_cnt_q <= '0;
      word_buf_q <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_buf_q <= word_buf_d;
    end
  end

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory loaded from a byte stream, then served combinationally to the core's fetch port.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [31:0]        addr,
  output logic [InstBus-1:0] inst,
  input  logic               ld_valid,
  input  logic [7:0]         ld_byte,
  input  logic               ld_last,
  output logic               ld_ready,
  input  logic               reload,
  output logic               rom_ready,
  output logic               load_ovf,
  output logic [ADDR_W:0]    words_loaded
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PtrOne = 1;
  localparam logic [ADDR_W:0]   CntOne = 1;

  rom_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     words_loaded_q, words_loaded_d;
  logic                load_ovf_q, load_ovf_d;

  logic [InstBus-1:0]  mem [Depth];
  logic [InstBus-1:0]  pk_word;
  logic                pk_we;
  logic                take;
  logic                reload_run;

  assign take       = ld_valid && ld_ready;
  assign reload_run = (state_q == RUN) && reload;

  rom_word_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .clr     (reload_run),
    .take    (take),
    .ld_byte (ld_byte),
    .ld_last (ld_last),
    .word    (pk_word),
    .we      (pk_we)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= LOAD;
      wr_ptr_q       <= '0;
      words_loaded_q <= '0;
      load_ovf_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      words_loaded_q <= words_loaded_d;
      load_ovf_q     <= load_ovf_d;
    end
  end

  // Storage is deliberately not reset so a reload can overwrite only part of the image.
  always_ff @(posedge clk) begin
    if (pk_we) mem[wr_ptr_q] <= pk_word;
  end

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    words_loaded_d = words_loaded_q;
    load_ovf_d     = load_ovf_q;
    case (state_q)
      LOAD: begin
        if (pk_we) begin
          wr_ptr_d       = wr_ptr_q + PtrOne;
          words_loaded_d = words_loaded_q + CntOne;
          if (ld_last) begin
            state_d = RUN;
          end else if (wr_ptr_q == '1) begin
            state_d    = RUN;
            load_ovf_d = 1'b1;
          end
        end
      end
      default: begin
        if (reload) begin
          state_d        = LOAD;
          wr_ptr_d       = '0;
          words_loaded_d = '0;
          load_ovf_d     = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    ld_ready     = (state_q == LOAD) && rst;
    rom_ready    = (state_q == RUN);
    load_ovf     = load_ovf_q;
    words_loaded = words_loaded_q;
    inst         = ZeroWord;
    if ((state_q == RUN) && ce && ((addr >> (ADDR_W + 2)) == 32'd0))
      inst = mem[addr[ADDR_W+1:2]];
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: default-depth instance plus a 4-word instance for overflow.
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, ld_valid, ld_last, reload;
  logic [31:0] addr, inst;
  logic [7:0]  ld_byte;
  logic        ld_ready, rom_ready, load_ovf;
  logic [10:0] words_loaded;

  logic        ce_s, ld_valid_s, ld_last_s, reload_s;
  logic [31:0] addr_s, inst_s;
  logic [7:0]  ld_byte_s;
  logic        ld_ready_s, rom_ready_s, load_ovf_s;
  logic [2:0]  words_loaded_s;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  inst_rom_loader #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst),
    .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready),
    .reload(reload), .rom_ready(rom_ready), .load_ovf(load_ovf), .words_loaded(words_loaded)
  );

  inst_rom_loader #(.ADDR_W(2)) dut_s (
    .clk(clk), .rst(rst), .ce(ce_s), .addr(addr_s), .inst(inst_s),
    .ld_valid(ld_valid_s), .ld_byte(ld_byte_s), .ld_last(ld_last_s), .ld_ready(ld_ready_s),
    .reload(reload_s), .rom_ready(rom_ready_s), .load_ovf(load_ovf_s), .words_loaded(words_loaded_s)
  );

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic [31:0] exp;
  } fetch_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    ld_valid = 1'b1; ld_byte = b; ld_last = last;
    step();
    ld_valid = 1'b0; ld_last = 1'b0; ld_byte = 8'h00;
  endtask

  task automatic fetch(input string name, input logic [31:0] a, input logic [31:0] exp);
    ce = 1'b1; addr = a;
    #1;
    check(name, inst, exp);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  fetch_vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0000, 32'h3401_0001};
    vecs[1] = '{1'b1, 32'h0000_0004, 32'h3402_0002};
    vecs[2] = '{1'b1, 32'h0000_0005, 32'h3402_0002};
    vecs[3] = '{1'b1, 32'h0000_0003, 32'h3401_0001};
    vecs[4] = '{1'b0, 32'h0000_0004, 32'h0000_0000};
    vecs[5] = '{1'b1, 32'h0001_0000, 32'h0000_0000};
    vecs[6] = '{1'b1, 32'h0000_1000, 32'h0000_0000};

    rst = 1'b0; ce = 1'b0; addr = '0; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0; reload = 1'b0;
    ce_s = 1'b0; addr_s = '0; ld_valid_s = 1'b0; ld_byte_s = '0; ld_last_s = 1'b0; reload_s = 1'b0;
    step(); step();
    check("rst_rom_ready", {31'd0, rom_ready}, 32'd0);
    check("rst_words", {21'd0, words_loaded}, 32'd0);
    check("rst_ovf", {31'd0, load_ovf}, 32'd0);
    check("rst_ld_ready_low", {31'd0, ld_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("ld_ready_after_rst", {31'd0, ld_ready}, 32'd1);

    fetch("inst_in_load", 32'h0, 32'h0);
    ce = 1'b0;

    // Two-word image
    send(8'h34, 1'b0); send(8'h01, 1'b0); send(8'h00, 1'b0); send(8'h01, 1'b0);
    check("words_after_1", {21'd0, words_loaded}, 32'd1);
    send(8'h34, 1'b0); send(8'h02, 1'b0); send(8'h00, 1'b0);
    check("not_ready_before_last", {31'd0, rom_ready}, 32'd0);
    send(8'h02, 1'b1);
    check("t1_words", {21'd0, words_loaded}, 32'd2);
    check("t1_rom_ready", {31'd0, rom_ready}, 32'd1);
    check("t1_ld_ready", {31'd0, ld_ready}, 32'd0);
    check("t1_ovf", {31'd0, load_ovf}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      ce = vecs[i].ce; addr = vecs[i].addr;
      #1;
      check($sformatf("fetch_vec%0d", i), inst, vecs[i].exp);
    end

    // Reload with a simultaneous byte: byte must be refused
    ld_valid = 1'b1; ld_byte = 8'h99; reload = 1'b1;
    #1;
    check("reload_ld_ready", {31'd0, ld_ready}, 32'd0);
    step();
    ld_valid = 1'b0; reload = 1'b0;
    check("reload_words", {21'd0, words_loaded}, 32'd0);
    check("reload_state_load", {31'd0, rom_ready}, 32'd0);
    check("reload_ld_ready_back", {31'd0, ld_ready}, 32'd1);
    send(8'hDE, 1'b0); send(8'hAD, 1'b0); send(8'hBE, 1'b0); send(8'hEF, 1'b1);
    check("t5_words", {21'd0, words_loaded}, 32'd1);
    fetch("t5_mem0", 32'h0, 32'hDEAD_BEEF);
    fetch("t5_mem1_kept", 32'h4, 32'h3402_0002);

    // Short final word is zero-padded
    pulse_reload();
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    send(8'h55, 1'b1);
    check("t2_words", {21'd0, words_loaded}, 32'd2);
    check("t2_rom_ready", {31'd0, rom_ready}, 32'd1);
    fetch("t2_mem0", 32'h0, 32'h1122_3344);
    fetch("t2_mem1_pad", 32'h4, 32'h5500_0000);

    // Reset mid-word discards the partial bytes
    pulse_reload();
    send(8'h77, 1'b0); send(8'h66, 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("t6_words_rst", {21'd0, words_loaded}, 32'd0);
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b1);
    check("t6_words", {21'd0, words_loaded}, 32'd1);
    fetch("t6_mem0", 32'h0, 32'hAABB_CCDD);
    fetch("t6_mem1_kept", 32'h4, 32'h5500_0000);

    // Overflow on the 4-word instance
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (ld_ready_s !== (i < 16)) begin
        n_fail++;
        $display("FAIL ovf_ld_ready_byte%0d: got %b expected %b", i + 1, ld_ready_s, (i < 16));
      end
      ld_valid_s = 1'b1; ld_byte_s = 8'(i + 1);
      step();
    end
    ld_valid_s = 1'b0;
    check("ovf_flag", {31'd0, load_ovf_s}, 32'd1);
    check("ovf_words", {29'd0, words_loaded_s}, 32'd4);
    check("ovf_rom_ready", {31'd0, rom_ready_s}, 32'd1);
    ce_s = 1'b1;
    addr_s = 32'h0;  #1; check("ovf_mem0", inst_s, 32'h0102_0304);
    addr_s = 32'h4;  #1; check("ovf_mem1", inst_s, 32'h0506_0708);
    addr_s = 32'h8;  #1; check("ovf_mem2", inst_s, 32'h090A_0B0C);
    addr_s = 32'hC;  #1; check("ovf_mem3", inst_s, 32'h0D0E_0F10);
    addr_s = 32'h10; #1; check("ovf_oor", inst_s, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
